// File: rtl/sync_pulse_train_if.sv
// Purpose: bundles the start/abort controls and the pulse-train status outputs of sync_pulse_train.
// Latency: n/a (signal bundle only).
// Backpressure: none; start is a level gate and outputs are free-running status.
//
// Signals:
//   pg_start  start gate, level, only the rising edge matters
//   pg_abort  synchronous abort, active high
//   pg_o      optical sync pulse output
//   pg_busy   burst in progress
//   pg_done   one-cycle strobe at normal burst completion
//   pg_num    number of rising edges emitted in the current/last burst
interface sync_pulse_train_if #(
    parameter int NUM_W = 16
);
    logic             pg_start;
    logic             pg_abort;
    logic             pg_o;
    logic             pg_busy;
    logic             pg_done;
    logic [NUM_W-1:0] pg_num;

    // master: the start logic / bench side
    modport master (
        output pg_start,
        output pg_abort,
        input  pg_o,
        input  pg_busy,
        input  pg_done,
        input  pg_num
    );

    // slave: the pulse generator side
    modport slave (
        input  pg_start,
        input  pg_abort,
        output pg_o,
        output pg_busy,
        output pg_done,
        output pg_num
    );
endinterface

// File: rtl/sync_pulse_train.sv
// Purpose: on a start-gate rising edge, emits a burst of PULSE_COUNT sync pulses (delay/width/period).
// Latency: first pulse rises START_DELAY cycles after the accept edge (same edge when START_DELAY=0).
// Backpressure: none; starts seen while busy are dropped, pg_busy tells the start logic to hold off.
//
// Ports:
//   pg_clk    system clock
//   pg_rst_n  asynchronous active-low reset
//   pg_if     slave side of sync_pulse_train_if (pg_start, pg_abort in; pg_o, pg_busy, pg_done, pg_num out)
module sync_pulse_train #(
    parameter int          CNT_W        = 32,
    parameter int          NUM_W        = 16,
    parameter int unsigned START_DELAY  = 0,
    parameter int unsigned PULSE_WIDTH  = 5,
    parameter int unsigned PULSE_PERIOD = 10,
    parameter int unsigned PULSE_COUNT  = 4
) (
    input  logic                 pg_clk,
    input  logic                 pg_rst_n,
    sync_pulse_train_if.slave    pg_if
);

    generate
        if (PULSE_WIDTH == 0 || PULSE_PERIOD <= PULSE_WIDTH || PULSE_COUNT == 0) begin : g_bad_params
            $error("sync_pulse_train: illegal PULSE_WIDTH/PULSE_PERIOD/PULSE_COUNT");
        end
    endgenerate

    // Counter load values: a phase of length L loads L-1 and advances on 0.
    // DLY_LOAD is only used when START_DELAY >= 1.
    localparam logic [CNT_W-1:0] DLY_LOAD  = CNT_W'(START_DELAY - 1);
    localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(PULSE_PERIOD - PULSE_WIDTH - 1);
    localparam logic [NUM_W-1:0] NUM_LAST  = NUM_W'(PULSE_COUNT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [NUM_W-1:0] num_q;
    logic             start_d;
    logic             o_q;
    logic             busy_q;
    logic             done_q;

    logic accept;
    logic cnt_zero;

    // Edge detect is only meaningful in IDLE; edges elsewhere are dropped, not queued.
    assign accept   = pg_if.pg_start & ~start_d & (state_q == IDLE);
    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge pg_clk or negedge pg_rst_n) begin
        if (!pg_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            num_q   <= '0;
            // History starts at 1 so a gate already high at reset release is not an edge.
            start_d <= 1'b1;
            o_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // History keeps tracking during abort so a held gate needs a fresh edge afterwards.
            start_d <= pg_if.pg_start;
            done_q  <= 1'b0;

            if (pg_if.pg_abort) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                o_q     <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (accept) begin
                            busy_q <= 1'b1;
                            if (START_DELAY == 0) begin
                                state_q <= HIGH;
                                cnt_q   <= HIGH_LOAD;
                                o_q     <= 1'b1;
                                num_q   <= NUM_W'(1);
                            end else begin
                                state_q <= DELAY;
                                cnt_q   <= DLY_LOAD;
                                num_q   <= '0;
                            end
                        end
                    end

                    DELAY: begin
                        if (cnt_zero) begin
                            state_q <= HIGH;
                            cnt_q   <= HIGH_LOAD;
                            o_q     <= 1'b1;
                            num_q   <= num_q + NUM_W'(1);
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end

                    HIGH: begin
                        if (cnt_zero) begin
                            state_q <= LOW;
                            cnt_q   <= LOW_LOAD;
                            o_q     <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end

                    LOW: begin
                        if (cnt_zero) begin
                            if (num_q == NUM_LAST) begin
                                // The final low phase is the guard interval; busy covers it.
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= HIGH;
                                cnt_q   <= HIGH_LOAD;
                                o_q     <= 1'b1;
                                num_q   <= num_q + NUM_W'(1);
                            end
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end

                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign pg_if.pg_o    = o_q;
    assign pg_if.pg_busy = busy_q;
    assign pg_if.pg_done = done_q;
    assign pg_if.pg_num  = num_q;

endmodule

// File: tb/tb_sync_pulse_train.sv
// Purpose: directed self-checking bench for sync_pulse_train using three parameterisations.
// Latency: n/a.
// Backpressure: n/a.
module tb_sync_pulse_train;

    logic pg_clk;
    logic pg_rst_n;

    int n_checks;
    int n_errs;

    sync_pulse_train_if #(.NUM_W(16)) a_if ();
    sync_pulse_train_if #(.NUM_W(16)) b_if ();
    sync_pulse_train_if #(.NUM_W(16)) c_if ();

    // A: delay 2, width 3, period 5, count 2
    sync_pulse_train #(
        .CNT_W(32), .NUM_W(16), .START_DELAY(2), .PULSE_WIDTH(3), .PULSE_PERIOD(5), .PULSE_COUNT(2)
    ) u_a (
        .pg_clk   (pg_clk),
        .pg_rst_n (pg_rst_n),
        .pg_if    (a_if.slave)
    );

    // B: delay 0, width 1, period 2, count 3
    sync_pulse_train #(
        .CNT_W(32), .NUM_W(16), .START_DELAY(0), .PULSE_WIDTH(1), .PULSE_PERIOD(2), .PULSE_COUNT(3)
    ) u_b (
        .pg_clk   (pg_clk),
        .pg_rst_n (pg_rst_n),
        .pg_if    (b_if.slave)
    );

    // C: delay 0, width 2, period 4, count 4
    sync_pulse_train #(
        .CNT_W(32), .NUM_W(16), .START_DELAY(0), .PULSE_WIDTH(2), .PULSE_PERIOD(4), .PULSE_COUNT(4)
    ) u_c (
        .pg_clk   (pg_clk),
        .pg_rst_n (pg_rst_n),
        .pg_if    (c_if.slave)
    );

    initial pg_clk = 1'b0;
    always #5 pg_clk = ~pg_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [15:0] o_pat;
    logic [15:0] busy_pat;
    logic [15:0] done_pat;
    logic        busy_acc;
    int          busy_cnt;
    int          done_cnt;

    initial begin
        n_checks = 0;
        n_errs   = 0;
        pg_rst_n = 1'b0;
        a_if.pg_start = 1'b0; a_if.pg_abort = 1'b0;
        b_if.pg_start = 1'b1; b_if.pg_abort = 1'b0;   // held high through reset
        c_if.pg_start = 1'b0; c_if.pg_abort = 1'b0;

        // ---------------- reset values ----------------
        #3;
        check_val("rst_a_o",    32'(a_if.pg_o),    32'd0);
        check_val("rst_a_busy", 32'(a_if.pg_busy), 32'd0);
        check_val("rst_a_done", 32'(a_if.pg_done), 32'd0);
        check_val("rst_a_num",  32'(a_if.pg_num),  32'd0);
        check_val("rst_b_busy", 32'(b_if.pg_busy), 32'd0);
        check_val("rst_c_o",    32'(c_if.pg_o),    32'd0);
        @(negedge pg_clk);
        @(negedge pg_clk);
        pg_rst_n = 1'b1;

        // ---------------- start held through reset: no burst ----------------
        busy_acc = 1'b0;
        repeat (4) begin
            @(negedge pg_clk);
            busy_acc |= b_if.pg_busy;
        end
        check_val("b_held_start_no_burst", 32'(busy_acc), 32'd0);

        // ---------------- zero-delay burst on B ----------------
        b_if.pg_start = 1'b0;
        @(negedge pg_clk);
        b_if.pg_start = 1'b1;
        o_pat = '0; busy_pat = '0; done_pat = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge pg_clk);
            o_pat[k]    = b_if.pg_o;
            busy_pat[k] = b_if.pg_busy;
            done_pat[k] = b_if.pg_done;
        end
        check_val("b_o_pattern",    32'(o_pat),    32'h0015);
        check_val("b_busy_pattern", 32'(busy_pat), 32'h003F);
        check_val("b_done_pattern", 32'(done_pat), 32'h0040);
        check_val("b_num_final",    32'(b_if.pg_num), 32'd3);

        // ---------------- nominal burst on A, start held past completion ----------------
        @(negedge pg_clk);
        a_if.pg_start = 1'b1;
        o_pat = '0; busy_pat = '0; done_pat = '0;
        for (int k = 0; k < 14; k++) begin
            @(negedge pg_clk);
            o_pat[k]    = a_if.pg_o;
            busy_pat[k] = a_if.pg_busy;
            done_pat[k] = a_if.pg_done;
        end
        check_val("a_o_pattern",    32'(o_pat),    32'h039C);
        check_val("a_busy_pattern", 32'(busy_pat), 32'h0FFF);
        check_val("a_done_pattern", 32'(done_pat), 32'h1000);
        check_val("a_num_final",    32'(a_if.pg_num), 32'd2);
        busy_acc = 1'b0;
        repeat (10) begin
            @(negedge pg_clk);
            busy_acc |= a_if.pg_busy;
        end
        check_val("a_hold_no_retrigger", 32'(busy_acc), 32'd0);

        // ---------------- retrigger immunity on A ----------------
        a_if.pg_start = 1'b0;
        @(negedge pg_clk);
        a_if.pg_start = 1'b1;
        busy_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge pg_clk);
            if (a_if.pg_busy) busy_cnt++;
            if (a_if.pg_done) done_cnt++;
            if (k == 1) a_if.pg_start = 1'b0;
            if (k == 2) a_if.pg_start = 1'b1;
            if (k == 3) a_if.pg_start = 1'b0;
            if (k == 4) a_if.pg_start = 1'b1;
        end
        check_val("a_retrig_busy_cycles", 32'(busy_cnt), 32'd12);
        check_val("a_retrig_done_count",  32'(done_cnt), 32'd1);
        check_val("a_retrig_num",         32'(a_if.pg_num), 32'd2);

        // ---------------- B: edge on the completion edge is ignored ----------------
        b_if.pg_start = 1'b0;
        @(negedge pg_clk);
        b_if.pg_start = 1'b1;
        busy_acc = 1'b0; done_cnt = 0;
        for (int k = 0; k < 13; k++) begin
            @(negedge pg_clk);
            if (k >= 6) busy_acc |= b_if.pg_busy;
            if (b_if.pg_done) done_cnt++;
            if (k == 3) b_if.pg_start = 1'b0;
            if (k == 5) b_if.pg_start = 1'b1;   // rising edge seen at the completion edge
        end
        check_val("b_edge_on_done_ignored", 32'(busy_acc), 32'd0);
        check_val("b_edge_on_done_dones",   32'(done_cnt), 32'd1);

        // ---------------- B: edge one cycle after completion starts a new burst ----------------
        b_if.pg_start = 1'b0;
        @(negedge pg_clk);
        b_if.pg_start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge pg_clk);
            if (k == 6) begin
                check_val("b2b_gap_busy", 32'(b_if.pg_busy), 32'd0);
                check_val("b2b_gap_done", 32'(b_if.pg_done), 32'd1);
            end
            if (k == 7) begin
                check_val("b2b_new_busy", 32'(b_if.pg_busy), 32'd1);
                check_val("b2b_new_num",  32'(b_if.pg_num),  32'd1);
                check_val("b2b_new_o",    32'(b_if.pg_o),    32'd1);
            end
            if (k == 3) b_if.pg_start = 1'b0;
            if (k == 6) b_if.pg_start = 1'b1;
        end
        repeat (8) @(negedge pg_clk);
        b_if.pg_start = 1'b0;

        // ---------------- abort during the 2nd HIGH on C ----------------
        c_if.pg_start = 1'b1;
        repeat (5) @(negedge pg_clk);
        check_val("c_pre_abort_o",   32'(c_if.pg_o),   32'd1);
        check_val("c_pre_abort_num", 32'(c_if.pg_num), 32'd2);
        c_if.pg_abort = 1'b1;
        @(negedge pg_clk);
        check_val("c_abort_o",    32'(c_if.pg_o),    32'd0);
        check_val("c_abort_busy", 32'(c_if.pg_busy), 32'd0);
        check_val("c_abort_num",  32'(c_if.pg_num),  32'd2);
        c_if.pg_abort = 1'b0;
        busy_acc = 1'b0; done_cnt = 0;
        repeat (20) begin
            @(negedge pg_clk);
            busy_acc |= c_if.pg_busy;
            if (c_if.pg_done) done_cnt++;
        end
        check_val("c_abort_no_done",    32'(done_cnt), 32'd0);
        check_val("c_abort_no_restart", 32'(busy_acc), 32'd0);

        // ---------------- abort and accept in the same IDLE cycle ----------------
        c_if.pg_start = 1'b0;
        @(negedge pg_clk);
        c_if.pg_start = 1'b1;
        c_if.pg_abort = 1'b1;
        @(negedge pg_clk);
        check_val("c_abort_vs_start_busy", 32'(c_if.pg_busy), 32'd0);
        check_val("c_abort_vs_start_o",    32'(c_if.pg_o),    32'd0);
        c_if.pg_abort = 1'b0;
        busy_acc = 1'b0;
        repeat (5) begin
            @(negedge pg_clk);
            busy_acc |= c_if.pg_busy;
        end
        check_val("c_abort_vs_start_later", 32'(busy_acc), 32'd0);
        check_val("c_abort_vs_start_num",   32'(c_if.pg_num), 32'd2);

        // ---------------- asynchronous reset mid-HIGH on A ----------------
        a_if.pg_start = 1'b0;
        @(negedge pg_clk);
        a_if.pg_start = 1'b1;
        repeat (3) @(negedge pg_clk);
        check_val("a_pre_reset_o", 32'(a_if.pg_o), 32'd1);
        #2;
        pg_rst_n = 1'b0;
        #1;
        check_val("a_async_rst_o",    32'(a_if.pg_o),    32'd0);
        check_val("a_async_rst_busy", 32'(a_if.pg_busy), 32'd0);
        check_val("a_async_rst_num",  32'(a_if.pg_num),  32'd0);
        @(negedge pg_clk);
        pg_rst_n = 1'b1;
        busy_acc = 1'b0;
        repeat (5) begin
            @(negedge pg_clk);
            busy_acc |= a_if.pg_busy;
        end
        check_val("a_rst_release_held_start", 32'(busy_acc), 32'd0);
        a_if.pg_start = 1'b0;
        @(negedge pg_clk);
        a_if.pg_start = 1'b1;
        @(negedge pg_clk);
        check_val("a_fresh_edge_busy", 32'(a_if.pg_busy), 32'd1);
        check_val("a_fresh_edge_o",    32'(a_if.pg_o),    32'd0);
        check_val("a_fresh_edge_num",  32'(a_if.pg_num),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
